// File: rtl/program_loader.sv
// program_loader: streams a program into instruction memory, checksum-verifies it, then releases the processor.
module program_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int MAX_WORDS   = 1024,
  parameter int HOLD_CYCLES = 2,
  parameter int VERIFY_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] init_pc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, VERIFY, HOLD, RUN} state_t;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W:0] MAXW = (ADDR_W+1)'(MAX_WORDS);
  state_t state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0] nwords, rd_cnt;
  logic [DATA_W-1:0] vsum;
  logic rd_v, rd_last, cmp_v, cmp_last;
  logic [HW-1:0] hcnt;
  logic len_ok, accept, last_acc;
  assign len_ok   = (num_words != '0) && (num_words <= MAXW);
  assign in_ready = (state == LOAD) && !abort;
  assign accept   = in_valid && in_ready;
  assign last_acc = accept && (words_loaded == nwords - 1'b1);
  assign cpu_rst  = (state != RUN);
  assign done     = (state == RUN);
  assign busy     = (state != IDLE) && (state != RUN);
  assign init_pc  = base;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      base         <= '0;
      nwords       <= '0;
      rd_cnt       <= '0;
      vsum         <= '0;
      rd_v         <= 1'b0;
      rd_last      <= 1'b0;
      cmp_v        <= 1'b0;
      cmp_last     <= 1'b0;
      hcnt         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      error        <= 1'b0;
      checksum     <= '0;
      words_loaded <= '0;
    end else begin
      imem_we  <= 1'b0;
      rd_v     <= 1'b0;
      cmp_v    <= rd_v;
      cmp_last <= rd_v && rd_last;
      if (abort) begin
        state <= IDLE;
        if (busy) error <= 1'b1;
      end else begin
        case (state)
          IDLE, RUN: if (start) begin
            if (len_ok) begin
              base         <= base_addr;
              nwords       <= num_words;
              checksum     <= '0;
              words_loaded <= '0;
              error        <= 1'b0;
              state        <= LOAD;
            end else begin
              error <= 1'b1;
              state <= IDLE;
            end
          end
          LOAD: if (accept) begin
            imem_we      <= 1'b1;
            imem_addr    <= base + words_loaded[ADDR_W-1:0];
            imem_wdata   <= in_data;
            checksum     <= checksum + in_data;
            words_loaded <= words_loaded + 1'b1;
            if (last_acc) state <= DRAIN;
          end
          DRAIN: begin
            rd_cnt <= '0;
            vsum   <= '0;
            hcnt   <= '0;
            state  <= (VERIFY_EN != 0) ? VERIFY : HOLD;
          end
          VERIFY: begin
            if (rd_cnt != nwords) begin
              imem_addr <= base + rd_cnt[ADDR_W-1:0];
              rd_v      <= 1'b1;
              rd_last   <= (rd_cnt == nwords - 1'b1);
              rd_cnt    <= rd_cnt + 1'b1;
            end
            // read data trails its address by one cycle, so compare is two edges behind issue
            if (cmp_v) begin
              vsum <= vsum + imem_rdata;
              if (cmp_last) begin
                if (vsum + imem_rdata == checksum) state <= HOLD;
                else begin
                  error <= 1'b1;
                  state <= IDLE;
                end
              end
            end
          end
          HOLD: if (hcnt == HW'(HOLD_CYCLES - 1)) state <= RUN;
                else hcnt <= hcnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; expected writes are queued at stimulus, popped by a write monitor.
module tb_program_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
  logic [9:0] base_addr = 0;
  logic [10:0] num_words = 0;
  logic [31:0] in_data = 0;
  logic in_ready, imem_we, cpu_rst, busy, done, error;
  logic [9:0] imem_addr, init_pc;
  logic [31:0] imem_wdata, imem_rdata, checksum;
  logic [10:0] words_loaded;
  int total = 0, bad = 0, cyc = 0, wr_cnt = 0, n0;
  int wr_cyc[$];
  logic [41:0] exp_q[$];
  logic [41:0] e;
  logic [31:0] mem [1024];
  logic corrupt = 0;
  logic [9:0] corrupt_addr = 10'd5;

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .cpu_rst(cpu_rst), .init_pc(init_pc), .busy(busy), .done(done), .error(error),
    .checksum(checksum), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (imem_we) mem[imem_addr] <= imem_wdata;
    imem_rdata <= mem[imem_addr] ^ ((corrupt && imem_addr == corrupt_addr) ? 32'd1 : 32'd0);
  end

  always @(negedge clk) if (rst && imem_we) begin
    wr_cnt++;
    wr_cyc.push_back(cyc);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL write: unexpected addr=%0d data=%0h", imem_addr, imem_wdata);
    end else begin
      e = exp_q.pop_front();
      if ({imem_addr, imem_wdata} !== e)
        begin bad++; $display("FAIL write: got addr=%0d data=%0h want addr=%0d data=%0h", imem_addr, imem_wdata, e[41:32], e[31:0]); end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic go(input logic [9:0] b, input logic [10:0] n);
    @(negedge clk);
    start = 1; base_addr = b; num_words = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic word(input logic [31:0] w, input logic [9:0] a);
    chk("in_ready", in_ready, 1);
    in_valid = 1; in_data = w;
    exp_q.push_back({a, w});
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 100 && !(done || error); i++) @(negedge clk);
    chk("finish", done || error, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst = 0;
    @(negedge clk);
    chk("rst cpu_rst", cpu_rst, 1);
    chk("rst in_ready", in_ready, 0);
    chk("rst imem_we", imem_we, 0);
    chk("rst imem_addr", imem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst checksum", checksum, 0);
    chk("rst words", words_loaded, 0);
    chk("rst init_pc", init_pc, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    wr_cyc.delete();
    go(0, 4);
    chk("basic busy", busy, 1);
    for (int k = 0; k < 4; k++) word(k + 1, k[9:0]);
    chk("basic ready drop", in_ready, 0);
    wait_end();
    chk("basic done", done, 1);
    chk("basic error", error, 0);
    chk("basic checksum", checksum, 10);
    chk("basic words", words_loaded, 4);
    chk("basic cpu_rst", cpu_rst, 0);
    chk("basic init_pc", init_pc, 0);
    chk("basic wr count", wr_cyc.size(), 4);
    chk("basic back2back", wr_cyc[3] - wr_cyc[0], 3);

    go(50, 2);
    chk("reload cpu_rst", cpu_rst, 1);
    chk("reload done", done, 0);
    chk("reload checksum clr", checksum, 0);
    word(9, 50);
    word(11, 51);
    wait_end();
    chk("reload done2", done, 1);
    chk("reload checksum", checksum, 20);
    chk("reload init_pc", init_pc, 50);
    chk("reload words", words_loaded, 2);

    n0 = wr_cnt;
    go(0, 1025);
    chk("len1025 error", error, 1);
    chk("len1025 busy", busy, 0);
    chk("len1025 done", done, 0);
    chk("len1025 cpu_rst", cpu_rst, 1);
    go(0, 0);
    chk("len0 error", error, 1);
    chk("len0 busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("badlen no writes", wr_cnt - n0, 0);

    n0 = wr_cnt;
    go(100, 3);
    chk("gap error clr", error, 0);
    word(5, 100);
    @(negedge clk);
    word(6, 101);
    @(negedge clk);
    word(7, 102);
    wait_end();
    chk("gap writes", wr_cnt - n0, 3);
    chk("gap words", words_loaded, 3);
    chk("gap checksum", checksum, 18);
    chk("gap done", done, 1);

    go(1022, 4);
    word(32'hA, 10'd1022);
    word(32'hB, 10'd1023);
    word(32'hC, 10'd0);
    word(32'hD, 10'd1);
    wait_end();
    chk("wrap done", done, 1);
    chk("wrap checksum", checksum, 46);
    chk("wrap init_pc", init_pc, 1022);
    chk("wrap pending", exp_q.size(), 0);

    go(200, 5);
    word(1, 200);
    word(2, 201);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort error", error, 1);
    chk("abort busy", busy, 0);
    chk("abort cpu_rst", cpu_rst, 1);
    chk("abort done", done, 0);
    chk("abort words", words_loaded, 2);
    chk("abort pending", exp_q.size(), 0);

    corrupt = 1;
    go(3, 4);
    word(32'h10, 3);
    word(32'h20, 4);
    word(32'h30, 5);
    word(32'h40, 6);
    wait_end();
    chk("corrupt error", error, 1);
    chk("corrupt done", done, 0);
    chk("corrupt cpu_rst", cpu_rst, 1);
    chk("corrupt busy", busy, 0);
    chk("corrupt checksum", checksum, 32'hA0);
    corrupt = 0;

    go(300, 4);
    word(7, 300);
    #1 rst = 0;
    #1;
    chk("midrst words", words_loaded, 0);
    chk("midrst checksum", checksum, 0);
    chk("midrst imem_we", imem_we, 0);
    chk("midrst busy", busy, 0);
    chk("midrst cpu_rst", cpu_rst, 1);
    @(negedge clk);
    rst = 1;
    go(310, 2);
    word(3, 310);
    word(4, 311);
    wait_end();
    chk("postrst done", done, 1);
    chk("postrst checksum", checksum, 7);
    chk("postrst words", words_loaded, 2);
    chk("postrst pending", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 10, instruction-memory word-address width.
- DATA_W, default 32, instruction width.
- MAX_WORDS, default 1024, largest accepted program length (at most 2^ADDR_W).
- HOLD_CYCLES, default 2, processor-reset hold after load (at least 1).
- VERIFY_EN, default 1, enables the readback-compare phase.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin load, sampled in IDLE or RUN.
- abort  in  1  cancel, any state.
- base_addr  in  ADDR_W  first word address.
- num_words  in  ADDR_W+1  program length.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  loader accepts a word.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  memory address (write or read).
- imem_wdata  out  DATA_W  write data.
- imem_rdata  in  DATA_W  read data, valid one cycle after imem_addr.
- cpu_rst  out  1  active-high processor reset.
- init_pc  out  ADDR_W  start PC for the processor.
- busy  out  1  state is not IDLE and not RUN.
- done  out  1  program loaded, processor released.
- error  out  1  sticky fault flag.
- checksum  out  DATA_W  sum of loaded words.
- words_loaded  out  ADDR_W+1  accepted word count.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, DRAIN, VERIFY, HOLD and RUN.
REQ-004 In IDLE, start=1 with 1<=num_words<=MAX_WORDS SHALL:
- latch base_addr and num_words;
- clear checksum, words_loaded and error;
- go to LOAD.
REQ-005 In IDLE, start=1 with num_words=0 or num_words>MAX_WORDS SHALL set error=1 and stay in IDLE.
REQ-006 in_ready SHALL be 1 only in LOAD; a word is accepted on any cycle with in_valid=1 and in_ready=1.
REQ-007 Each accepted word k (0-based) SHALL be written with a one-cycle registered latency: on the next cycle imem_we=1, imem_addr=(base+k) mod 2^ADDR_W, imem_wdata=word.
REQ-008 Each accepted word SHALL be added to checksum modulo 2^DATA_W and SHALL increment words_loaded.
REQ-009 Back-to-back accepts SHALL sustain one write per cycle; in_valid=0 inserts bubbles with imem_we=0.
REQ-010 Acceptance of word num_words-1 SHALL move the FSM to DRAIN, and in_ready SHALL drop in that same cycle.
REQ-011 DRAIN SHALL last one cycle, during which the final write is issued; the FSM then goes to VERIFY if VERIFY_EN=1, else to HOLD.
REQ-012 In VERIFY, the loader SHALL:
- issue read addresses base..base+num_words-1 (modulo 2^ADDR_W), one per cycle, with imem_we=0;
- compare each imem_rdata one cycle later against the recomputed running sum, which must equal checksum after the last word.
- The loader holds no copy of the program, so verify is by checksum only.
REQ-013 Outcome of VERIFY:
- a checksum mismatch after the last read SHALL set error=1, keep cpu_rst=1 and return to IDLE;
- a match SHALL go to HOLD.
REQ-014 HOLD SHALL keep cpu_rst=1 for exactly HOLD_CYCLES cycles, then go to RUN.
REQ-015 In RUN, cpu_rst SHALL be 0, done SHALL be 1, and init_pc SHALL equal the latched base_addr.
REQ-016 cpu_rst SHALL be 1 in every state except RUN.
REQ-017 start=1 in RUN SHALL act as in IDLE (REQ-004/005):
- cpu_rst rises in the same cycle, and done falls, for a valid reload;
- for an invalid length, error=1 and the FSM goes to IDLE.
REQ-018 abort=1 in any state SHALL go to IDLE on the next edge with error=1 only if the state was busy; an in-flight registered write SHALL still complete.
REQ-019 abort SHALL have priority over start, and start SHALL be ignored while busy=1.
REQ-020 Address wrap SHALL be silent: base+k past 2^ADDR_W-1 continues at 0.

Reset
REQ-021 While rst=0, asynchronously:
- state=IDLE, cpu_rst=1;
- in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
- init_pc=0, busy=0, done=0, error=0, checksum=0, words_loaded=0.
REQ-022 Reset asserted mid-LOAD or mid-VERIFY SHALL discard all progress; the following start begins from REQ-004.

Verification
REQ-023 Basic load: base=0, n=4, words 1,2,3,4, in_valid held high.
- Response: writes to addresses 0..3 on 4 consecutive cycles, checksum=10.
- With VERIFY_EN=1 and a memory model, done=1 after DRAIN+VERIFY+HOLD(2).
- cpu_rst=0, init_pc=0.
REQ-024 Gapped stream: n=3, in_valid toggled 1,0,1,0,1.
- Response: exactly 3 imem_we pulses, at addresses base..base+2, and words_loaded=3.
REQ-025 Wrap: base=1022, n=4.
- Response: write addresses 1022, 1023, 0, 1.
REQ-026 Corrupting model: memory returns word^1 at one address.
- Response: error=1, FSM back in IDLE, cpu_rst stays 1, done=0.
REQ-027 Bad length and abort:
- num_words=0 or 1025 -> error=1, no writes;
- abort after 2 of 5 words -> IDLE, error=1, cpu_rst=1.
REQ-028 Reload from RUN: start with n=2.
- Response: cpu_rst rises the same cycle, done falls, and the new load completes with checksum equal to the sum of the new words only.
